// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
// Feeds a fixed table of configuration bytes to i2c_controller for one display.
// A start pulse enables the controller. One table byte is loaded each time the
// controller reports ready, and every load is followed by a fixed gap. After the
// final byte has been accepted, enable drops and done pulses for one cycle.
// Build option: define I2C_SEQ_RETRY_EN to restart the table after a NACK,
// with a backoff period, up to MAX_RETRIES times. Without it, a NACK ends the
// sequence with an error.
module i2c_init_sequencer #(
   parameter logic [6:0]   SLAVE_ADDR  = 7'h3C,
   parameter int unsigned  NUM_BYTES   = 16,
   parameter logic [127:0] INIT_TABLE  = 128'h3C00_3800_3900_1478_5E6D_0C01_0600_4041,
   parameter int unsigned  GAP_CYCLES  = 5,
   parameter int unsigned  MAX_RETRIES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic [4:0] byte_count_o,
   output logic       ctl_enable_o,
   output logic [6:0] ctl_addr_o,
   output logic [7:0] ctl_data_o,
   output logic       ctl_rw_o,
   input  logic       ctl_ready_i,
   input  logic       ctl_nack_i
);

   localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
   localparam logic [4:0]      LastIdx = 5'(NUM_BYTES);
`ifdef I2C_SEQ_RETRY_EN
   localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StWaitRdy,
      StGap,
      StDrain,
      StBackoff
   } state_e;

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [4:0]        idx_q, idx_d;
   logic [4:0]        byte_count_q, byte_count_d;
   logic              ctl_enable_q, ctl_enable_d;
   logic [7:0]        ctl_data_q, ctl_data_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [RetryW-1:0] retry_q, retry_d;

   // Entry 0 sits in the top byte of INIT_TABLE, so it maps to element 15.
   logic [15:0][7:0] table_w;
   logic [7:0]       entry_w;
   logic             nack_hit_w;

   assign table_w = INIT_TABLE;
   assign entry_w = table_w[4'd15 - idx_q[3:0]];

   // A NACK only matters while the controller is enabled by this block.
   assign nack_hit_w = ctl_nack_i &&
                       ((state_q == StWaitRdy) || (state_q == StGap) || (state_q == StDrain));

   // Next-state and output register computation.
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = error_q;
      idx_d        = idx_q;
      byte_count_d = byte_count_q;
      ctl_enable_d = ctl_enable_q;
      ctl_data_d   = ctl_data_q;
      gap_d        = gap_q;
      retry_d      = retry_q;

      case (state_q)
         StIdle: begin
            ctl_enable_d = 1'b0;
            // A start coinciding with the done pulse belongs to the old sequence.
            if (start_i && !done_q) begin
               state_d      = StWaitRdy;
               busy_d       = 1'b1;
               ctl_enable_d = 1'b1;
               idx_d        = 5'd0;
               byte_count_d = 5'd0;
               error_d      = 1'b0;
               retry_d      = '0;
            end
         end

         StWaitRdy: begin
            if (ctl_ready_i) begin
               ctl_data_d   = entry_w;
               idx_d        = idx_q + 5'd1;
               byte_count_d = idx_q + 5'd1;
               gap_d        = '0;
               state_d      = StGap;
            end
         end

         StGap: begin
            // Ready is deliberately ignored here so a long ready cannot double-load.
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
               state_d = (idx_q == LastIdx) ? StDrain : StWaitRdy;
            end
         end

         StDrain: begin
            if (ctl_ready_i) begin
               ctl_enable_d = 1'b0;
               done_d       = 1'b1;
               busy_d       = 1'b0;
               state_d      = StIdle;
            end
         end

`ifdef I2C_SEQ_RETRY_EN
         StBackoff: begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
               idx_d        = 5'd0;
               byte_count_d = 5'd0;
               ctl_enable_d = 1'b1;
               retry_d      = retry_q + RetryW'(1);
               state_d      = StWaitRdy;
            end
         end
`endif

         default: begin
            state_d      = StIdle;
            busy_d       = 1'b0;
            ctl_enable_d = 1'b0;
         end
      endcase

      // NACK overrides whatever the state decided this cycle.
      if (nack_hit_w) begin
`ifdef I2C_SEQ_RETRY_EN
         if (retry_q == RetryMax) begin
            ctl_enable_d = 1'b0;
            error_d      = 1'b1;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            state_d      = StIdle;
         end else begin
            ctl_enable_d = 1'b0;
            gap_d        = '0;
            state_d      = StBackoff;
         end
`else
         ctl_enable_d = 1'b0;
         error_d      = 1'b1;
         done_d       = 1'b1;
         busy_d       = 1'b0;
         state_d      = StIdle;
`endif
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         idx_q        <= 5'd0;
         byte_count_q <= 5'd0;
         ctl_enable_q <= 1'b0;
         ctl_data_q   <= 8'h00;
         gap_q        <= '0;
         retry_q      <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         idx_q        <= idx_d;
         byte_count_q <= byte_count_d;
         ctl_enable_q <= ctl_enable_d;
         ctl_data_q   <= ctl_data_d;
         gap_q        <= gap_d;
         retry_q      <= retry_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign byte_count_o = byte_count_q;
   assign ctl_enable_o = ctl_enable_q;
   assign ctl_data_o   = ctl_data_q;
   assign ctl_addr_o   = SLAVE_ADDR;
   assign ctl_rw_o     = 1'b0;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer
// Directed bench for i2c_init_sequencer. A transaction-level model predicts
// every output on every cycle. Hand-written literal checks pin the following:
// the reset state, the order of the loaded bytes, the spacing between loads,
// the number of done pulses, and the behaviour on reset and on NACK.
module tb_i2c_init_sequencer;

   localparam int NB   = 16;
   localparam int GAP  = 5;
   localparam int MAXR = 3;
`ifdef I2C_SEQ_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       ctl_ready;
   logic       ctl_nack = 1'b0;
   logic       busy, done, error, en, rw;
   logic [4:0] bc;
   logic [6:0] addr;
   logic [7:0] data;

   i2c_init_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error),
      .byte_count_o (bc),
      .ctl_enable_o (en),
      .ctl_addr_o   (addr),
      .ctl_data_o   (data),
      .ctl_rw_o     (rw),
      .ctl_ready_i  (ctl_ready),
      .ctl_nack_i   (ctl_nack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdy_mode = 0;  // 0 off, 1 one-cycle pulse every 4 cycles, 2 held high
   logic [7:0] exp_tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Controller stand-in: ready pattern chosen by the running test.
   always @(negedge clk) ctl_ready <= (rdy_mode == 2) || (rdy_mode == 1 && (cyc % 4) == 0);

   // Transaction model: a sequence is "bytes sent so far" plus a cooldown
   // countdown after each load and a backoff countdown after a retried NACK.
   logic       m_busy, m_done, m_err, m_en;
   logic [7:0] m_data;
   int         m_cnt, m_cool, m_back, m_retry;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_err <= 0; m_en <= 0; m_data <= 8'h00;
         m_cnt <= 0; m_cool <= 0; m_back <= 0; m_retry <= 0;
      end else if (!m_busy) begin
         m_done <= 0;
         m_en   <= 0;
         if (start && !m_done) begin
            m_busy <= 1; m_en <= 1; m_cnt <= 0; m_err <= 0;
            m_cool <= 0; m_back <= 0; m_retry <= 0;
         end
      end else if (ctl_nack && m_back == 0) begin
         if (RETRY && m_retry < MAXR) begin
            m_back <= GAP;
            m_en   <= 0;
         end else begin
            m_en <= 0; m_err <= 1; m_done <= 1; m_busy <= 0;
         end
      end else if (m_back > 0) begin
         m_back <= m_back - 1;
         if (m_back == 1) begin
            m_cnt <= 0; m_en <= 1; m_retry <= m_retry + 1; m_cool <= 0;
         end
      end else if (m_cool > 0) begin
         m_cool <= m_cool - 1;
      end else if (ctl_ready) begin
         if (m_cnt == NB) begin
            m_en <= 0; m_done <= 1; m_busy <= 0;
         end else begin
            m_data <= exp_tbl[m_cnt];
            m_cnt  <= m_cnt + 1;
            m_cool <= GAP;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("error", error, m_err);
      check("byte_count", bc, m_cnt);
      check("ctl_enable", en, m_en);
      check("ctl_data", data, m_data);
      check("ctl_addr", addr, 7'h3C);
      check("ctl_rw", rw, 1'b0);
   end

   // Observation of loads (byte_count steps) and done pulses.
   int         done_count = 0;
   int         prev_bc = 0;
   logic [7:0] loads[$];
   int         stamps[$];

   always @(negedge clk) begin
      if (done === 1'b1) done_count <= done_count + 1;
      if (int'(bc) != prev_bc && bc != 5'd0) begin
         loads.push_back(data);
         stamps.push_back(cyc);
      end
      prev_bc <= int'(bc);
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_loads(input int n, input int budget);
      int k = 0;
      while (loads.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_loads_timeout", loads.size() >= n, 1'b1);
   endtask

   task automatic wait_done(input int base, input int budget);
      int k = 0;
      while (done_count <= base && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_done_timeout", done_count > base, 1'b1);
   endtask

   task automatic check_seq(input int from, input string tag);
      for (int i = 0; i < NB; i++) begin
         check($sformatf("%s_byte%0d", tag, i), loads[from + i], exp_tbl[i]);
      end
   endtask

   task automatic check_spacing(input int from, input bit exact);
      for (int i = 1; i < NB; i++) begin
         if (exact) check("spacing_exact", stamps[from + i] - stamps[from + i - 1], 6);
         else check("spacing_min", (stamps[from + i] - stamps[from + i - 1]) >= 6, 1'b1);
      end
   endtask

   initial begin
      int l0, d0, k;
      exp_tbl = '{8'h3C, 8'h00, 8'h38, 8'h00, 8'h39, 8'h00, 8'h14, 8'h78,
                  8'h5E, 8'h6D, 8'h0C, 8'h01, 8'h06, 8'h00, 8'h40, 8'h41};

      // Reset state, then idle with no start.
      repeat (3) @(negedge clk);
      check("rst_enable", en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_count", bc, 5'd0);
      check("rst_data", data, 8'h00);
      check("rst_addr", addr, 7'h3C);
      check("rst_rw", rw, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_enable", en, 1'b0);
      check("idle_busy", busy, 1'b0);
      ctl_nack = 1'b1;
      @(negedge clk);
      ctl_nack = 1'b0;
      @(negedge clk);
      check("idle_nack_error", error, 1'b0);

      // Pulsed ready; a start arriving with done is ignored.
      rdy_mode = 1;
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
      k = 0;
      while (done !== 1'b1 && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("pulse_done_seen", done, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_done_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      check("start_on_done_idle", busy, 1'b0);
      check("pulse_enable_after", en, 1'b0);
      check("pulse_loads", loads.size() - l0, NB);
      check("pulse_count", bc, 5'd16);
      check("pulse_dones", done_count - d0, 1);
      check_seq(l0, "pulse");
      check_spacing(l0, 1'b0);

      // Ready held high: exact spacing, no double loads.
      rdy_mode = 2;
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
      wait_done(d0, 300);
      repeat (3) @(negedge clk);
      check("hold_loads", loads.size() - l0, NB);
      check("hold_dones", done_count - d0, 1);
      check_seq(l0, "hold");
      check_spacing(l0, 1'b1);

      // Start repulsed while byte 5 is in flight.
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
      repeat (27) @(negedge clk);
      pulse_start();
      wait_done(d0, 300);
      repeat (10) @(negedge clk);
      check("repulse_loads", loads.size() - l0, NB);
      check("repulse_dones", done_count - d0, 1);
      check_seq(l0, "repulse");

      // Reset after the 8th load, then a fresh sequence from the top.
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
      wait_loads(l0 + 8, 200);
      #2 rst = 1'b1;
      #1;
      check("midrst_enable", en, 1'b0);
      check("midrst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_no_done", done_count - d0, 0);
      check("midrst_error", error, 1'b0);
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
      wait_done(d0, 300);
      @(negedge clk);
      check("midrst_first", loads[l0], 8'h3C);
      check("midrst_loads", loads.size() - l0, NB);

      // NACK after the 3rd load.
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
`ifdef I2C_SEQ_RETRY_EN
      for (int a = 1; a <= MAXR + 1; a++) begin
         wait_loads(l0 + 3 * a, 200);
         ctl_nack = 1'b1;
         @(negedge clk);
         ctl_nack = 1'b0;
      end
      wait_done(d0, 100);
      @(negedge clk);
      check("nack_loads", loads.size() - l0, 12);
      check("nack_restart_first", loads[l0 + 9], 8'h3C);
`else
      wait_loads(l0 + 3, 200);
      ctl_nack = 1'b1;
      @(negedge clk);
      ctl_nack = 1'b0;
      wait_done(d0, 100);
      @(negedge clk);
      check("nack_loads", loads.size() - l0, 3);
`endif
      check("nack_error", error, 1'b1);
      check("nack_count", bc, 5'd3);
      check("nack_dones", done_count - d0, 1);
      check("nack_enable", en, 1'b0);

      // The next accepted start clears the sticky error.
      l0 = loads.size();
      d0 = done_count;
      pulse_start();
      check("clear_error", error, 1'b0);
      wait_done(d0, 300);
      @(negedge clk);
      check("clear_error_end", error, 1'b0);
      check("clear_loads", loads.size() - l0, NB);

      rdy_mode = 0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Drives `i2c_controller` through a fixed table of up to 16 configuration bytes for the display at 7-bit address 0x3C.
- On a start pulse it enables the controller, feeds one byte per controller ready, and keeps a minimum gap between feeds. It then drops enable and pulses done.
- Sits in `i2c_top` between the board-level reset/start logic and `i2c_controller`, and replaces the hard-tied enable/addr/data_in/rw connections.

Parameters:
- SLAVE_ADDR, 7'h3C, value driven on ctl_addr.
- NUM_BYTES, 16, number of table entries sent (1..16).
- INIT_TABLE, 128'h3C00_3800_3900_1478_5E6D_0C01_0600_4041, byte table; entry 0 = bits [127:120], entry k = bits [127-8k -: 8].
- GAP_CYCLES, 5, clk cycles in GAP after each byte load (≥1).
- MAX_RETRIES, 3, restart attempts on NACK (used only with I2C_SEQ_RETRY_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send the table; ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sequence ends (success or error).
- error  out  1  sticky; set on a failed sequence, cleared by the next accepted start.
- byte_count  out  5  number of bytes loaded so far in the current sequence.
- ctl_enable  out  1  to controller enable.
- ctl_addr  out  7  to controller addr; constant SLAVE_ADDR.
- ctl_data  out  8  to controller data_in.
- ctl_rw  out  1  to controller rw; constant 0 (write).
- ctl_ready  in  1  from controller; high while it can latch the next data byte.
- ctl_nack  in  1  from controller; one-cycle pulse on a NACK.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, error=0, byte_count=0, ctl_enable=0, ctl_data=8'h00, idx=0, gap counter=0, retry counter=0.
- ctl_addr=SLAVE_ADDR and ctl_rw=0 at all times, including during reset.
- IDLE:
  - ctl_enable=0.
  - start=1 → next cycle: state=WAIT_RDY, busy=1, ctl_enable=1, idx=0, byte_count=0, error=0.
- WAIT_RDY:
  - On ctl_ready=1: ctl_data<=INIT_TABLE entry idx, idx<=idx+1, byte_count<=idx+1, gap<=0, state=GAP.
  - This is exactly one load per WAIT_RDY visit.
- GAP:
  - ctl_ready is ignored, so a multi-cycle ready never causes a double load.
  - gap increments each cycle.
  - When gap==GAP_CYCLES-1: if idx==NUM_BYTES → DRAIN, else → WAIT_RDY.
  - Load-to-next-load spacing is therefore ≥GAP_CYCLES+1 cycles.
- DRAIN:
  - Waits for ctl_ready=1, meaning the controller accepted the last byte.
  - Then: ctl_enable<=0, done pulse for 1 cycle, busy<=0, state=IDLE.
- ctl_data holds its last value until the next load; it is not cleared on return to IDLE.
- start while busy: ignored, with no effect on idx or state.
- start in the same cycle as done: ignored; a new start must come at least 1 cycle after done.
- ctl_nack when not busy: ignored.
- rst asserted mid-sequence: ctl_enable drops the same instant, no done pulse, error=0.
- idx is 5 bits and never exceeds NUM_BYTES; no wrap-around.

Optional Feature:
- Macro: I2C_SEQ_RETRY_EN.
- Without the macro:
  - ctl_nack=1 in any busy state → ctl_enable<=0, error<=1, done pulse, state=IDLE.
  - byte_count holds the number of bytes loaded so far.
- With the macro:
  - ctl_nack in any busy state → ctl_enable<=0 for GAP_CYCLES cycles (state BACKOFF), then idx=0, byte_count=0, ctl_enable=1, state=WAIT_RDY, retry counter +1.
  - A NACK arriving when the retry counter == MAX_RETRIES → error<=1, done pulse, IDLE.
  - The retry counter clears on an accepted start.

Test Plan:
- Reset then idle, no start → ctl_enable=0, busy=0, done=0, error=0, ctl_addr=7'h3C, ctl_rw=0.
- start pulse, controller model asserts ctl_ready 1 cycle each time it is polled → 16 loads in order 3C,00,38,00,39,00,14,78,5E,6D,0C,01,06,00,40,41; each load ≥6 cycles apart; byte_count ends at 16; one done pulse; ctl_enable low after done.
- ctl_ready held high continuously → still exactly 16 loads, spaced exactly 6 cycles apart; no duplicate bytes.
- start repulsed during byte 5 → sequence unaffected, 16 bytes total, single done.
- rst asserted after the 8th byte load → ctl_enable=0 and busy=0 immediately; no done; a later start resends from 3C.
- NACK after the 3rd load:
  - without I2C_SEQ_RETRY_EN → error=1, done, byte_count=3.
  - with I2C_SEQ_RETRY_EN and NACK on every attempt → 3 restarts from 3C, then error=1 and done on the 4th NACK.
